// File: rtl/counter_step_gen.sv
`timescale 1ns/1ps
// counter_step_gen: input conditioning and step-clock generator feeding the
// 4-bit up/down/bounce counter.
//   clk        board clock, all logic on the rising edge
//   Reset      asynchronous, active-high reset
//   mode_raw   raw mode switch (1 = bounce, 0 = manual direction)
//   sw_raw     raw direction switch (1 = up, 0 = down)
//   pause_raw  raw pause push-button, active-high
//   div_sel    step-rate select, period = DIV_MAX >> div_sel (minimum 2)
//   step_clk   step clock, falling edge = one counter step
//   step_tick  one-cycle pulse coincident with the step_clk falling edge
//   mode_db    debounced mode_raw
//   sw_db      debounced sw_raw
//   running    1 = stepping enabled, 0 = paused
module counter_step_gen #(
    parameter int unsigned DIV_WIDTH       = 24,
    parameter int unsigned DIV_MAX         = 12500000,
    parameter int unsigned DB_WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       mode_raw,
    input  logic       sw_raw,
    input  logic       pause_raw,
    input  logic [1:0] div_sel,
    output logic       step_clk,
    output logic       step_tick,
    output logic       mode_db,
    output logic       sw_db,
    output logic       running
);

    localparam int unsigned NUM_IN    = 3;
    localparam int unsigned IDX_MODE  = 0;
    localparam int unsigned IDX_SW    = 1;
    localparam int unsigned IDX_PAUSE = 2;

    localparam logic [DIV_WIDTH-1:0] DIV_MAX_W  = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(2);
    localparam logic [DB_WIDTH-1:0]  DB_LAST    = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Effective period for a rate select: shifted base period, never below 2.
    function automatic logic [DIV_WIDTH-1:0] eff_period(input logic [1:0] sel);
        logic [DIV_WIDTH-1:0] p;
        p = DIV_MAX_W >> sel;
        if (p < MIN_PERIOD) begin
            p = MIN_PERIOD;
        end
        return p;
    endfunction

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] db_vec;

    assign raw_vec = {pause_raw, sw_raw, mode_raw};

    // Per-input 2-FF synchronizer followed by a stable-count debouncer.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_db
        logic                s1_q, s1_d;
        logic                s2_q, s2_d;
        logic                db_q, db_d;
        logic [DB_WIDTH-1:0] cnt_q, cnt_d;

        always_comb begin
            s1_d  = raw_vec[g];
            s2_d  = s1_q;
            db_d  = db_q;
            cnt_d = cnt_q;
            if (s2_q == db_q) begin
                // Agreement (or a bounce back) discards any partial count.
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_d = '0;
                db_d  = s2_q;
            end else begin
                cnt_d = cnt_q + DB_WIDTH'(1);
            end
        end

        always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                db_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= s1_d;
                s2_q  <= s2_d;
                db_q  <= db_d;
                cnt_q <= cnt_d;
            end
        end

        assign db_vec[g] = db_q;
    end

    logic                 pause_prev_q, pause_prev_d;
    logic                 running_q, running_d;
    logic                 init_q, init_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic                 step_clk_q, step_clk_d;
    logic                 step_tick_q, step_tick_d;
    logic                 pause_rise_c;
    logic [DIV_WIDTH-1:0] period_cur_c;
    logic [DIV_WIDTH-1:0] half_c;

    // Only a rising edge of the debounced button toggles the run state.
    assign pause_rise_c = db_vec[IDX_PAUSE] & ~pause_prev_q;

    // On the first edge after reset the period comes straight from div_sel.
    assign period_cur_c = init_q ? eff_period(div_sel) : period_q;
    assign half_c       = period_cur_c >> 1;

    // Pause toggle and prescaler; the prescaler sees the pre-toggle run state.
    always_comb begin
        pause_prev_d = db_vec[IDX_PAUSE];
        running_d    = running_q ^ pause_rise_c;
        init_d       = 1'b0;
        cnt_d        = cnt_q;
        period_d     = period_cur_c;
        step_clk_d   = step_clk_q;
        step_tick_d  = 1'b0;
        if (running_q) begin
            if (cnt_q == period_cur_c - DIV_WIDTH'(1)) begin
                cnt_d       = '0;
                step_tick_d = 1'b1;
                step_clk_d  = 1'b0;
                period_d    = eff_period(div_sel);
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
                if (cnt_q == half_c - DIV_WIDTH'(1)) begin
                    step_clk_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pause_prev_q <= 1'b0;
            running_q    <= 1'b1;
            init_q       <= 1'b1;
            cnt_q        <= '0;
            period_q     <= MIN_PERIOD;
            step_clk_q   <= 1'b0;
            step_tick_q  <= 1'b0;
        end else begin
            pause_prev_q <= pause_prev_d;
            running_q    <= running_d;
            init_q       <= init_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            step_clk_q   <= step_clk_d;
            step_tick_q  <= step_tick_d;
        end
    end

    assign step_clk  = step_clk_q;
    assign step_tick = step_tick_q;
    assign mode_db   = db_vec[IDX_MODE];
    assign sw_db     = db_vec[IDX_SW];
    assign running   = running_q;

endmodule

// File: tb/tb_counter_step_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for counter_step_gen: a behavioural model queues the
// expected outputs after every clock edge, a monitor compares on the
// following falling edge; directed checks cover the timing corner cases.
module tb_counter_step_gen;

    localparam int DIV_MAX = 16;
    localparam int DC      = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic       mode_raw, sw_raw, pause_raw;
    logic [1:0] div_sel;
    logic       step_clk, step_tick, mode_db, sw_db, running;

    counter_step_gen #(
        .DIV_WIDTH      (24),
        .DIV_MAX        (DIV_MAX),
        .DB_WIDTH       (16),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .mode_raw (mode_raw),
        .sw_raw   (sw_raw),
        .pause_raw(pause_raw),
        .div_sel  (div_sel),
        .step_clk (step_clk),
        .step_tick(step_tick),
        .mode_db  (mode_db),
        .sw_db    (sw_db),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic step_clk;
        logic step_tick;
        logic mode_db;
        logic sw_db;
        logic running;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    // Behavioural model state.
    bit [2:0] m_hist[$];    // raw samples taken at each edge since reset
    bit [2:0] m_s2win[$];   // last DC synchronized samples seen by the debouncers
    bit [2:0] m_db;
    bit       m_pause_prev;
    bit       m_running;
    bit       m_init;
    int       m_pos;
    int       m_period;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int eff(input logic [1:0] sel);
        int p;
        p = DIV_MAX >> sel;
        if (p < 2) p = 2;
        return p;
    endfunction

    // True when every synchronized sample in the window has channel ch equal to v.
    function automatic bit window_all(input int ch, input bit v);
        bit ok;
        bit b;
        bit [2:0] w;
        ok = 1'b1;
        foreach (m_s2win[j]) begin
            w = m_s2win[j];
            b = (ch == 0) ? w[0] : ((ch == 1) ? w[1] : w[2]);
            if (b != v) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_s2win.delete();
        exp_q.delete();
        m_db         = 3'b000;
        m_pause_prev = 1'b0;
        m_running    = 1'b1;
        m_init       = 1'b1;
        m_pos        = 0;
        m_period     = 0;
    endtask

    task automatic model_step();
        bit [2:0] raw;
        bit [2:0] s2;
        bit [2:0] db_pre;
        bit       toggle;
        bit       run_pre;
        out_t     e;
        raw = {pause_raw, sw_raw, mode_raw};
        // Two synchronizer stages: the debouncer sees the value sampled two edges ago.
        s2 = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 3'b000;
        m_hist.push_back(raw);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_s2win.push_back(s2);
        if (m_s2win.size() > DC) void'(m_s2win.pop_front());
        db_pre = m_db;
        // A debounced level changes once DC consecutive samples disagree with it.
        if (m_s2win.size() == DC) begin
            if (window_all(0, ~db_pre[0])) m_db[0] = ~db_pre[0];
            if (window_all(1, ~db_pre[1])) m_db[1] = ~db_pre[1];
            if (window_all(2, ~db_pre[2])) m_db[2] = ~db_pre[2];
        end
        toggle       = db_pre[2] & ~m_pause_prev;
        m_pause_prev = db_pre[2];
        run_pre      = m_running;
        m_running    = m_running ^ toggle;
        e.step_tick  = 1'b0;
        if (m_init) begin
            m_period = eff(div_sel);
            m_init   = 1'b0;
        end
        if (run_pre) begin
            if (m_pos == m_period - 1) begin
                m_pos       = 0;
                e.step_tick = 1'b1;
                m_period    = eff(div_sel);
            end else begin
                m_pos++;
            end
        end
        // step_clk is low for the first half (rounded down) of each period.
        e.step_clk = (m_pos >= m_period / 2);
        e.mode_db  = m_db[0];
        e.sw_db    = m_db[1];
        e.running  = m_running;
        exp_q.push_back(e);
    endtask

    // Reference model process.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge Reset);
            if (Reset) model_reset();
            else       model_step();
        end
    end

    // Monitor: compares the DUT against the queued expectation away from the edge.
    out_t mon_e, mon_a;
    initial begin
        forever begin
            @(negedge clk);
            if (!Reset && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {step_clk, step_tick, mode_db, sw_db, running};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got clk/tick/mode/sw/run=%b expected %b",
                             $time, mon_a, mon_e);
                end
            end
        end
    end

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_tick !== 1'b1 && n < max);
        if (step_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout t=%0t got no tick expected one within %0d cycles", $time, max);
            n = -1;
        end
    endtask

    task automatic press_pause(input int hold);
        pause_raw = 1'b1;
        repeat (hold) @(negedge clk);
        pause_raw = 1'b0;
    endtask

    task automatic count_ticks(input int cycles, output int t);
        t = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (step_tick === 1'b1) t++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish expected end of test", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        Reset = 1'b0; mode_raw = 1'b0; sw_raw = 1'b0; pause_raw = 1'b0; div_sel = 2'd0;
        #1 Reset = 1'b1;
        #1;
        check_bit("rst_step_clk",  step_clk,  1'b0);
        check_bit("rst_step_tick", step_tick, 1'b0);
        check_bit("rst_mode_db",   mode_db,   1'b0);
        check_bit("rst_sw_db",     sw_db,     1'b0);
        check_bit("rst_running",   running,   1'b1);
        repeat (2) @(negedge clk);
        #2 Reset = 1'b0;

        // Base period 16: ticks after edges 15, 31, 47; step_clk high for edges 7..14.
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            check_bit($sformatf("base_tick_e%0d", i), step_tick, 1'((i % 16) == 15));
            check_bit($sformatf("base_clk_e%0d", i), step_clk,
                      1'(((i % 16) >= 7) && ((i % 16) != 15)));
        end

        // A 3-cycle glitch is rejected; a held level appears 6 edges later.
        sw_raw = 1'b1;
        repeat (3) @(negedge clk);
        sw_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("sw_glitch_rejected", sw_db, 1'b0);
        sw_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) check_bit("sw_db_edge5", sw_db, 1'b0);
            if (i == 6) check_bit("sw_db_edge6", sw_db, 1'b1);
        end

        // Rate change at cnt=5 completes the current 16-cycle period first.
        wait_tick(40, n);
        repeat (5) @(negedge clk);
        div_sel = 2'd3;
        wait_tick(40, n);
        check_int("div_change_period", n + 5, 16);
        wait_tick(40, n);
        check_int("fast_period", n, 2);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_bit($sformatf("fast_clk_%0d", i), step_clk, 1'((i % 2) == 1));
            check_bit($sformatf("fast_tick_%0d", i), step_tick, 1'((i % 2) == 0));
        end

        // Holding the button toggles once; a second press resumes.
        press_pause(20);
        check_bit("pause_running", running, 1'b0);
        count_ticks(30, t);
        check_int("paused_ticks", t, 0);
        press_pause(20);
        repeat (10) @(negedge clk);
        check_bit("resume_running", running, 1'b1);

        // Pause toggle landing exactly on the terminal-count edge.
        div_sel = 2'd0;
        wait_tick(40, n);
        wait_tick(40, n);
        check_int("period_16_again", n, 16);
        repeat (9) @(negedge clk);
        pause_raw = 1'b1;
        repeat (7) @(negedge clk);
        check_bit("tc_pause_tick", step_tick, 1'b1);
        check_bit("tc_pause_running", running, 1'b0);
        repeat (13) @(negedge clk);
        pause_raw = 1'b0;
        count_ticks(30, t);
        check_int("tc_paused_ticks", t, 0);
        press_pause(20);
        repeat (10) @(negedge clk);

        // Randomized input activity, checked by the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 19))
                0: mode_raw  = ~mode_raw;
                1: sw_raw    = ~sw_raw;
                2: pause_raw = ~pause_raw;
                3: div_sel   = 2'($urandom_range(0, 3));
                default: ;
            endcase
        end
        pause_raw = 1'b0;
        repeat (10) @(negedge clk);
        if (!m_running) begin
            press_pause(20);
            repeat (10) @(negedge clk);
        end

        // Reset mid-period with step_clk high and a debounce in progress.
        div_sel = 2'd0;
        wait_tick(40, n);
        wait_tick(40, n);
        repeat (9) @(negedge clk);
        check_bit("pre_reset_clk_high", step_clk, 1'b1);
        mode_raw = ~mode_raw;
        repeat (3) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        check_bit("mid_rst_step_clk",  step_clk,  1'b0);
        check_bit("mid_rst_step_tick", step_tick, 1'b0);
        check_bit("mid_rst_mode_db",   mode_db,   1'b0);
        check_bit("mid_rst_sw_db",     sw_db,     1'b0);
        check_bit("mid_rst_running",   running,   1'b1);
        repeat (2) @(negedge clk);
        #2 Reset = 1'b0;
        wait_tick(40, n);
        check_int("first_tick_after_reset", n, 16);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_step_gen.md
Name: counter_step_gen

Overview:
- Input-conditioning and step-clock stage placed directly upstream of the 4-bit up/down/bounce counter.
- Turns the fast board clock and raw slide switches / push-button into the counter's inputs:
  - a slow step clock whose falling edge advances the counter;
  - debounced mode and direction levels;
  - a pause/run toggle that freezes stepping.

Parameters:
- DIV_WIDTH, 24, width of prescaler counter and period register.
- DIV_MAX, 12500000, base step period in clk cycles (div_sel=00); must be at most 2^DIV_WIDTH-1.
- DB_WIDTH, 16, width of each debounce counter.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced output changes; must be at least 1 and at most 2^DB_WIDTH-1.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- Reset  input  1  reset, asynchronous, active-high.
- mode_raw  input  1  raw mode switch (1 = bounce, 0 = manual direction).
- sw_raw  input  1  raw direction switch (1 = up, 0 = down).
- pause_raw  input  1  raw pause push-button, active-high.
- div_sel  input  2  step-rate select.
- step_clk  output  1  step clock to counter; falling edge = one step.
- step_tick  output  1  one-cycle pulse coincident with step_clk falling.
- mode_db  output  1  debounced mode_raw.
- sw_db  output  1  debounced sw_raw.
- running  output  1  1 = stepping enabled, 0 = paused.

Behaviour:
- Reset values (async assert, all registers):
  - step_clk=0, step_tick=0, mode_db=0, sw_db=0, running=1;
  - synchronizers, debounce counters and prescaler cnt = 0;
  - period = eff(div_sel) sampled at reset release.
- Synchronizer:
  - each raw input passes through a 2-FF synchronizer (s1, s2).
- Debouncer (one per input, identical):
  - if s2 == db: counter cleared;
  - else counter increments; when it reaches DEBOUNCE_CYCLES-1 it clears and db takes s2 on that edge;
  - any return of s2 to db before then clears the counter (bounce rejected);
  - latency: a raw level held stable appears on db exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
- Pause:
  - rising edge of pause_db (registered previous value) toggles running;
  - falling edge of pause_db has no effect;
  - holding the button gives a single toggle.
- Period:
  - eff(sel) = DIV_MAX >> sel, clamped to a minimum of 2;
  - period register reloads from div_sel only at reset and on each terminal count;
  - a div_sel change mid-period takes effect from the next period, with no truncated or extended period.
- Prescaler, when running=1:
  - cnt counts 0..period-1, then wraps to 0;
  - terminal count (cnt==period-1): step_tick=1 for one cycle, step_clk cleared to 0, period reloaded;
  - when cnt == (period>>1)-1: step_clk set to 1;
  - result: step_clk is low for period>>1 cycles per period, high for the rest.
- Prescaler, when running=0:
  - cnt, step_clk and period hold;
  - step_tick=0;
  - resuming continues from the held cnt.
- Simultaneous events:
  - a pause toggle on the terminal-count edge uses the pre-toggle running value, so the tick still fires when pausing;
  - on resume, the first increment occurs on the edge after running becomes 1.
- Reset mid-operation:
  - outputs go to reset values immediately, independent of clk;
  - the prescaler restarts at 0 after release;
  - in-progress debounce counts are discarded.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
Bench parameters: DIV_MAX=16, DEBOUNCE_CYCLES=4.
- Reset release, div_sel=00, inputs 0 -> step_tick pulses at cycles 15, 31, 47; step_clk rises at cnt=7 and falls with each tick; mode_db=sw_db=0, running=1.
- sw_raw 0->1 held -> sw_db=1 exactly 6 edges later. sw_raw pulsed high for 3 cycles -> sw_db stays 0.
- div_sel 00->11 at cnt=5 -> current period completes at 16 cycles; following periods are 2 cycles (16>>3=2); step_clk toggles every cycle.
- pause_raw held high for 20 cycles -> running=0 once after debounce; cnt and step_clk frozen, no ticks. Second press -> running=1, counting resumes from the held cnt.
- Pause toggle landing on the terminal-count edge -> that tick is issued, then no further ticks.
- Reset asserted mid-period with step_clk=1 and a debounce in progress -> all outputs at reset values asynchronously; first tick 16 cycles after release.
